// File: rtl/tff_bank.sv
// tff_bank: a bank of WIDTH toggle flip-flops that can run as independent
// T flip-flops, a ripple-style up counter or a down counter, with a
// parallel load and a synchronous reset.
// Optional build macro TFF_BANK_SAT_EN makes the count modes saturate
// instead of wrapping; the default build wraps modulo 2^WIDTH.
module tff_bank #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] up_carry;
    logic [WIDTH-1:0] dn_borrow;
    logic [WIDTH-1:0] toggle_vec;
    logic             all_ones;
    logic             all_zeros;
    logic             count_step;
    logic             wrap_next;

    assign mode_sel = mode_e'(mode);

    // Complement output follows q directly
    assign qbar = ~q;

    // Per-bit toggle conditions: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        up_carry     = '0;
        dn_borrow    = '0;
        up_carry[0]  = 1'b1;
        dn_borrow[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_carry[i]  = up_carry[i-1]  & q[i-1];
            dn_borrow[i] = dn_borrow[i-1] & ~q[i-1];
        end
    end

    // Terminal count depends only on q and mode, never on en
    always_comb begin
        all_ones  = &q;
        all_zeros = ~|q;
        tc        = 1'b0;
        if (mode_sel == MODE_UP) begin
            tc = all_ones;
        end else if (mode_sel == MODE_DOWN) begin
            tc = all_zeros;
        end
    end

    // Select which bits toggle this edge and whether the step wraps
    always_comb begin
        toggle_vec = '0;
        count_step = en & ~load & ((mode_sel == MODE_UP) | (mode_sel == MODE_DOWN));
        wrap_next  = 1'b0;
        case (mode_sel)
            MODE_HOLD:   toggle_vec = '0;
            MODE_TOGGLE: toggle_vec = t;
            MODE_UP:     toggle_vec = up_carry;
            MODE_DOWN:   toggle_vec = dn_borrow;
            default:     toggle_vec = '0;
        endcase
`ifdef TFF_BANK_SAT_EN
        // Saturating build: a count step at the terminal value holds q and never flags wrap
        if (count_step && tc) begin
            toggle_vec = '0;
        end
        wrap_next = 1'b0;
`else
        // Wrapping build: flag a count step taken at the terminal value
        wrap_next = count_step & tc;
`endif
    end

    // State register: reset, then load, then enabled mode update, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
            if (load) begin
                q <= d;
            end else if (en) begin
                q <= q ^ toggle_vec;
            end
        end
    end

endmodule

// File: tb/tb_tff_bank.sv
// Directed, self-checking bench for tff_bank (WIDTH=4, RST_VAL=0).
// Each step drives inputs, pushes the model's expectation to a scoreboard
// queue, and pops/compares it after the clock edge.
module tb_tff_bank;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] RV = 4'h0;
`ifdef TFF_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] qbar;
        logic         tc;
        logic         wrap;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         tc;
    logic         wrap;

    exp_t  sb_q[$];
    string sb_tag[$];

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] m_q = RV;
    logic         m_wrap = 1'b0;

    tff_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .t    (t),
        .load (load),
        .d    (d),
        .q    (q),
        .qbar (qbar),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic ld, input logic [W-1:0] dd,
                        input logic e, input logic [1:0] md, input logic [W-1:0] tt,
                        input string tag);
        exp_t  ex;
        exp_t  got;
        string tg;
        logic  term;
        @(negedge clk);
        rst = r; load = ld; d = dd; en = e; mode = md; t = tt;
        // Reference model of the next state
        term = ((md == 2'b10) && (m_q == 4'hF)) || ((md == 2'b11) && (m_q == 4'h0));
        if (r) begin
            m_q = RV; m_wrap = 1'b0;
        end else if (ld) begin
            m_q = dd; m_wrap = 1'b0;
        end else if (e) begin
            m_wrap = 1'b0;
            case (md)
                2'b01: m_q = m_q ^ tt;
                2'b10: begin
                    if (!(SAT && term)) m_q = m_q + 4'd1;
                    m_wrap = term && !SAT;
                end
                2'b11: begin
                    if (!(SAT && term)) m_q = m_q - 4'd1;
                    m_wrap = term && !SAT;
                end
                default: m_q = m_q;
            endcase
        end else begin
            m_wrap = 1'b0;
        end
        ex.q    = m_q;
        ex.qbar = ~m_q;
        ex.tc   = ((md == 2'b10) && (m_q == 4'hF)) || ((md == 2'b11) && (m_q == 4'h0));
        ex.wrap = m_wrap;
        sb_q.push_back(ex);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        ex  = sb_q.pop_front();
        tg  = sb_tag.pop_front();
        got = '{q: q, qbar: qbar, tc: tc, wrap: wrap};
        vectors++;
        assert (got.q === ex.q) else begin
            errors++;
            $error("FAIL %s.q observed=%h expected=%h", tg, got.q, ex.q);
        end
        vectors++;
        assert (got.qbar === ex.qbar) else begin
            errors++;
            $error("FAIL %s.qbar observed=%h expected=%h", tg, got.qbar, ex.qbar);
        end
        vectors++;
        assert (got.tc === ex.tc) else begin
            errors++;
            $error("FAIL %s.tc observed=%b expected=%b", tg, got.tc, ex.tc);
        end
        vectors++;
        assert (got.wrap === ex.wrap) else begin
            errors++;
            $error("FAIL %s.wrap observed=%b expected=%b", tg, got.wrap, ex.wrap);
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; d = '0; en = 1'b0; mode = 2'b00; t = '0;
        // Reset overrides a simultaneous load
        step(1, 1, 4'hF, 0, 2'b00, 4'h0, "reset");
        // Toggle bank
        step(0, 0, 4'h0, 1, 2'b01, 4'h5, "tog_5");
        step(0, 0, 4'h0, 1, 2'b01, 4'h3, "tog_3");
        // Count-up wrap from E
        step(0, 1, 4'hE, 0, 2'b10, 4'h0, "load_e");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "up_1");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "up_2");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "up_3");
        // Count-down with an enable gap
        step(0, 1, 4'h2, 0, 2'b11, 4'h0, "load_2");
        step(0, 0, 4'h0, 1, 2'b11, 4'h0, "dn_1");
        step(0, 0, 4'h0, 0, 2'b11, 4'h0, "dn_gap");
        step(0, 0, 4'h0, 1, 2'b11, 4'h0, "dn_2");
        step(0, 0, 4'h0, 1, 2'b11, 4'h0, "dn_3");
        // Priority: load beats count, reset beats load
        step(0, 1, 4'h9, 1, 2'b10, 4'h0, "prio_load");
        step(1, 1, 4'h9, 1, 2'b10, 4'h0, "prio_rst");
        // Reset mid-count
        step(0, 1, 4'h3, 0, 2'b10, 4'h0, "load_3");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "cnt_4");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "cnt_5");
        step(1, 0, 4'h0, 1, 2'b10, 4'h0, "mid_rst");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "resume_1");
        step(0, 0, 4'h0, 1, 2'b10, 4'h0, "resume_2");
        // Hold mode and disabled toggle
        step(0, 0, 4'h0, 1, 2'b00, 4'hF, "hold");
        step(0, 0, 4'h0, 0, 2'b01, 4'hF, "tog_off");
        // Down from zero: tc then wrap to F
        step(0, 1, 4'h0, 0, 2'b11, 4'h0, "load_0");
        step(0, 0, 4'h0, 1, 2'b11, 4'h0, "dn_wrap");
        // tc is independent of en; toggle after a wrap clears wrap
        step(0, 0, 4'h0, 0, 2'b10, 4'h0, "tc_en0");
        step(0, 0, 4'h0, 1, 2'b01, 4'hA, "tog_a");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tff_bank.md
TFF_BANK -- requirements
Module: tff_bank

Interface
REQ-001 Parameter WIDTH, default 4, sets the number of toggle flip-flops (channels), legal range 1..32.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), sets the value loaded into q on reset.
REQ-003 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port en  input  1  is the global enable; when 0, mode-driven updates are suppressed.
REQ-006 Port mode  input  2  selects the operation: 00 hold, 01 toggle bank, 10 count up, 11 count down.
REQ-007 Port t  input  WIDTH  carries per-channel toggle requests, used in mode 01 only.
REQ-008 Port load  input  1  requests a parallel load of d.
REQ-009 Port d  input  WIDTH  carries the parallel load data.
REQ-010 Port q  output  WIDTH  is the registered state.
REQ-011 Port qbar  output  WIDTH  is the bitwise complement of q, combinational from q.
REQ-012 Port tc  output  1  is the terminal-count indicator, combinational.
REQ-013 Port wrap  output  1  is a registered one-cycle pulse that flags a counter wrap.

Function
REQ-014 Update priority per rising edge SHALL be: rst, then load, then (en and mode), then hold.
REQ-015 load=1 SHALL give q <= d on the next edge, regardless of en or mode.
REQ-016 en=1, mode=00 SHALL hold q.
REQ-017 en=1, mode=01: each bit i SHALL update as q[i] <= q[i] XOR t[i]; t=0 holds the bit, t=1 toggles it.
REQ-018 en=1, mode=10: q SHALL increment by 1 modulo 2^WIDTH, using T-flip-flop structure (bit i toggles when bits i-1..0 are all 1).
REQ-019 en=1, mode=11: q SHALL decrement by 1 modulo 2^WIDTH (bit i toggles when bits i-1..0 are all 0).
REQ-020 Latency: every update SHALL be visible on q one edge after it is sampled; qbar and tc follow q with no added delay.
REQ-021 tc SHALL be 1 only in these two cases:
  - mode=10 and q = all ones;
  - mode=11 and q = all zeros.
  tc SHALL be 0 otherwise, and tc is independent of en.
REQ-022 wrap SHALL be 1 for exactly the cycle after an edge on which a count step occurred with tc=1.
REQ-023 wrap SHALL be 0 after load, hold, toggle-bank steps and reset.
REQ-024 A mode change SHALL take effect on the same edge it is sampled; there is no pipeline flush or extra state.
REQ-025 With WIDTH=1, modes 01, 10 and 11 SHALL all behave as a single T flip-flop (toggle when enabled/requested).

Reset
REQ-026 rst=1 at an edge SHALL set q=RST_VAL, qbar=~RST_VAL and wrap=0, overriding load, en and mode.
REQ-027 Reset asserted mid-count SHALL discard the pending step; counting SHALL resume from RST_VAL on the first edge with rst=0.
REQ-028 There SHALL be no asynchronous reset path; q SHALL be undefined until the first reset edge.

Configuration
REQ-029 Macro TFF_BANK_SAT_EN: when defined, modes 10 and 11 SHALL saturate.
  - At all ones in mode 10, or all zeros in mode 11, q SHALL hold.
  - wrap SHALL stay 0.
  - tc behaviour is unchanged.
REQ-030 Without TFF_BANK_SAT_EN, counts SHALL wrap modulo 2^WIDTH as in REQ-018 and REQ-019, and wrap SHALL pulse per REQ-022.

Verification
REQ-031 Reset, WIDTH=4, RST_VAL=0: rst=1 for 1 edge with load=1, d=F -> q=0, qbar=F, wrap=0.
REQ-032 Toggle bank: q=0, en=1, mode=01, t=5 for 1 edge, then t=3 for 1 edge -> q=5, then q=6.
REQ-033 Count-up wrap: load d=E, then en=1, mode=10 for 3 edges -> q sequence E, F, 0, 1.
  - tc=1 while q=F.
  - wrap=1 only in the cycle q=0.
  - With TFF_BANK_SAT_EN: q sequence E, F, F, F and wrap=0 throughout.
REQ-034 Count-down with en gap: load d=2, mode=11, en pattern 1,0,1,1 -> q sequence 1, 1, 0, F.
  - wrap=1 in the cycle q=F.
REQ-035 Priority: on one edge, load=1 with d=9, en=1, mode=10 -> q=9 (not A); on the next edge, rst=1 with load=1 -> q=0.
REQ-036 Reset mid-count: count up from 3, assert rst at q=5 -> q=0 next edge; release rst -> q=1, 2, ...
